// File: rtl/conv_pkg.sv
// Shared register map, field positions and reset-default constants for the
// convolution engine control/status block.
package conv_pkg;

  localparam logic [31:0] ID_VAL_DEFAULT = 32'h434F_4E56;

  // Word offsets, i.e. the value of addr[4:2]
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_STATUS = 3'd1;
  localparam logic [2:0] OFF_CYCLES = 3'd2;
  localparam logic [2:0] OFF_RUNS   = 3'd3;
  localparam logic [2:0] OFF_ID     = 3'd4;
  localparam logic [2:0] OFF_LAST   = OFF_ID;

  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int STAT_BUSY_BIT   = 0;
  localparam int STAT_DONE_BIT   = 1;

endpackage

// File: rtl/conv_csr.sv
// CPU-facing control/status registers for the convolution engine: start pulse,
// busy/done tracking, cycle and run counters, and a completion interrupt.
module conv_csr
  import conv_pkg::*;
#(
  parameter logic [31:0] ID_VAL = ID_VAL_DEFAULT,
  parameter int          CYC_W  = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_icb_cmd_valid,
  output logic        csr_icb_cmd_ready,
  input  logic [31:0] csr_icb_cmd_addr,
  input  logic        csr_icb_cmd_read,
  input  logic [31:0] csr_icb_cmd_wdata,
  input  logic [3:0]  csr_icb_cmd_wmask,
  output logic        csr_icb_rsp_valid,
  input  logic        csr_icb_rsp_ready,
  output logic [31:0] csr_icb_rsp_rdata,
  output logic        csr_icb_rsp_err,
  output logic        conv_start,
  input  logic        conv_done,
  output logic        irq
);

  logic             r_rsp_valid;
  logic [31:0]      r_rsp_rdata;
  logic             r_rsp_err;
  logic             r_start;
  logic             r_irq;
  logic             r_busy;
  logic             r_done;
  logic             r_irq_en;
  logic             r_done_q;
  logic [CYC_W-1:0] r_cycles;
  logic [15:0]      r_runs;

  logic        w_accept;
  logic [2:0]  w_idx;
  logic        w_wr;
  logic        w_bad_addr;
  logic        w_ctrl_wr;
  logic        w_start_ok;
  logic        w_start_err;
  logic        w_w1c;
  logic        w_done_rise;
  logic [31:0] w_rdata;

  // Held low during reset so no command can slip in before release.
  assign csr_icb_cmd_ready = ~r_rsp_valid & ~rst;
  assign csr_icb_rsp_valid = r_rsp_valid;
  assign csr_icb_rsp_rdata = r_rsp_rdata;
  assign csr_icb_rsp_err   = r_rsp_err;
  assign conv_start        = r_start;
  assign irq               = r_irq;

  always_comb begin
    w_accept    = csr_icb_cmd_valid & csr_icb_cmd_ready;
    w_idx       = csr_icb_cmd_addr[4:2];
    w_wr        = w_accept & ~csr_icb_cmd_read;
    w_bad_addr  = (w_idx > OFF_LAST);
    w_ctrl_wr   = w_wr & (w_idx == OFF_CTRL) & csr_icb_cmd_wmask[0];
    w_start_ok  = w_ctrl_wr & csr_icb_cmd_wdata[CTRL_START_BIT] & ~r_busy;
    w_start_err = w_ctrl_wr & csr_icb_cmd_wdata[CTRL_START_BIT] & r_busy;
    w_w1c       = w_wr & (w_idx == OFF_STATUS) & csr_icb_cmd_wmask[0]
                  & csr_icb_cmd_wdata[STAT_DONE_BIT];
    w_done_rise = conv_done & ~r_done_q & r_busy;

    w_rdata = '0;
    case (w_idx)
      OFF_CTRL:   w_rdata[CTRL_IRQ_EN_BIT] = r_irq_en;
      OFF_STATUS: begin
        w_rdata[STAT_BUSY_BIT] = r_busy;
        w_rdata[STAT_DONE_BIT] = r_done;
      end
      OFF_CYCLES: w_rdata = 32'(r_cycles);
      OFF_RUNS:   w_rdata = {16'h0000, r_runs};
      OFF_ID:     w_rdata = ID_VAL;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_start     <= 1'b0;
      r_irq       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_irq_en    <= 1'b0;
      r_done_q    <= 1'b0;
      r_cycles    <= '0;
      r_runs      <= '0;
    end else begin
      r_done_q <= conv_done;
      r_start  <= w_start_ok;
      r_irq    <= r_done & r_irq_en;

      if (w_accept) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= csr_icb_cmd_read ? w_rdata : 32'h0;
        r_rsp_err   <= w_bad_addr | w_start_err;
      end else if (r_rsp_valid && csr_icb_rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end

      if (w_ctrl_wr)
        r_irq_en <= csr_icb_cmd_wdata[CTRL_IRQ_EN_BIT];

      if (w_start_ok)
        r_busy <= 1'b1;
      else if (w_done_rise)
        r_busy <= 1'b0;

      // A completion arriving alongside a W1C must not be lost.
      if (w_done_rise)
        r_done <= 1'b1;
      else if (w_start_ok || w_w1c)
        r_done <= 1'b0;

      if (w_start_ok)
        r_cycles <= '0;
      else if (r_busy && (r_cycles != {CYC_W{1'b1}}))
        r_cycles <= r_cycles + {{(CYC_W-1){1'b0}}, 1'b1};

      if (w_done_rise)
        r_runs <= r_runs + 16'd1;
    end
  end

endmodule

// File: tb/tb_conv_csr.sv
// Self-checking bench for conv_csr: directed scenarios plus randomized
// register traffic checked against a register-level model.
module tb_conv_csr;

  logic        clk;
  logic        rst;
  logic        cmdValid;
  logic        cmdReady;
  logic [31:0] cmdAddr;
  logic        cmdRead;
  logic [31:0] cmdWdata;
  logic [3:0]  cmdWmask;
  logic        rspValid;
  logic        rspReady;
  logic [31:0] rspRdata;
  logic        rspErr;
  logic        convStart;
  logic        convDone;
  logic        irq;

  int nCmp;
  int nFail;
  int startPulses;

  // Register-level model of the programmer-visible state
  logic        mIrqEn;
  logic        mDone;
  logic        mBusy;
  int unsigned mRuns;

  conv_csr dut (
    .clk               (clk),
    .rst               (rst),
    .csr_icb_cmd_valid (cmdValid),
    .csr_icb_cmd_ready (cmdReady),
    .csr_icb_cmd_addr  (cmdAddr),
    .csr_icb_cmd_read  (cmdRead),
    .csr_icb_cmd_wdata (cmdWdata),
    .csr_icb_cmd_wmask (cmdWmask),
    .csr_icb_rsp_valid (rspValid),
    .csr_icb_rsp_ready (rspReady),
    .csr_icb_rsp_rdata (rspRdata),
    .csr_icb_rsp_err   (rspErr),
    .conv_start        (convStart),
    .conv_done         (convDone),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (convStart) startPulses++;

  function automatic logic [31:0] modelRead(input logic [2:0] idx);
    case (idx)
      3'd0:    return {30'd0, mIrqEn, 1'b0};
      3'd1:    return {30'd0, mDone, mBusy};
      3'd3:    return mRuns & 32'h0000_FFFF;
      3'd4:    return 32'h434F_4E56;
      default: return 32'h0;
    endcase
  endfunction

  task automatic busAccess(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] mask, output logic [31:0] rdata,
                           output logic err, output logic lat1);
    int guard;
    @(negedge clk);
    cmdValid = 1'b1;
    cmdRead  = rd;
    cmdAddr  = addr;
    cmdWdata = wdata;
    cmdWmask = mask;
    rspReady = 1'b1;
    guard = 0;
    while (!cmdReady && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!cmdReady) begin
      nCmp++;
      nFail++;
      $display("[TB] FAIL bus_ready_timeout addr=%h", addr);
    end
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    lat1  = rspValid;
    rdata = rspRdata;
    err   = rspErr;
  endtask

  task automatic startRun();
    logic [31:0] rd;
    logic er, l1;
    busAccess(1'b0, 32'h0, 32'h3, 4'hF, rd, er, l1);
    mBusy = 1'b1;
    mDone = 1'b0;
    mIrqEn = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic er, l1;
    rst = 1'b1;
    #1;
    nCmp++;
    if ({cmdReady, rspValid, rspRdata, rspErr, convStart, irq} !== 37'd0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs got rdy=%b vld=%b rdata=%h err=%b start=%b irq=%b want all 0",
               cmdReady, rspValid, rspRdata, rspErr, convStart, irq);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    nCmp++;
    if (cmdReady !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL reset_ready got %b want 1", cmdReady);
    end
    for (int i = 0; i < 4; i++) begin
      busAccess(1'b1, 32'(i * 4), 32'h0, 4'h0, rd, er, l1);
      nCmp++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL reset_reg%0d got %h err=%b want 0 err=0", i, rd, er);
      end
    end
  endtask

  task automatic test_id();
    logic [31:0] rd;
    logic er, l1;
    busAccess(1'b1, 32'h10, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h434F_4E56 || er !== 1'b0 || l1 !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL id_read got %h err=%b vld=%b want 434f4e56 err=0 vld=1", rd, er, l1);
    end
  endtask

  task automatic test_run();
    logic [31:0] rd;
    logic er, l1;
    int p0;
    p0 = startPulses;
    startRun();
    busAccess(1'b1, 32'h4, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h1 || (startPulses - p0) !== 1) begin
      nFail++;
      $display("[TB] FAIL run_start got status=%h pulses=%0d want 1 and 1", rd, startPulses - p0);
    end
    repeat (100) @(negedge clk);
    convDone = 1'b1;
    mBusy = 1'b0;
    mDone = 1'b1;
    mRuns++;
    repeat (3) @(negedge clk);
    busAccess(1'b1, 32'h4, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h2) begin
      nFail++;
      $display("[TB] FAIL run_status got %h want 2", rd);
    end
    busAccess(1'b1, 32'h8, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd < 32'd98 || rd > 32'd108) begin
      nFail++;
      $display("[TB] FAIL run_cycles got %0d want 98..108", rd);
    end
    busAccess(1'b1, 32'hC, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== mRuns) begin
      nFail++;
      $display("[TB] FAIL run_runs got %0d want %0d", rd, mRuns);
    end
    nCmp++;
    if (irq !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL run_irq got %b want 1", irq);
    end
    convDone = 1'b0;
  endtask

  task automatic test_start_busy();
    logic [31:0] rd;
    logic er, l1;
    int p0;
    startRun();
    repeat (3) @(negedge clk);
    p0 = startPulses;
    busAccess(1'b0, 32'h0, 32'h3, 4'h1, rd, er, l1);
    repeat (3) @(negedge clk);
    nCmp++;
    if (er !== 1'b1 || startPulses !== p0) begin
      nFail++;
      $display("[TB] FAIL busy_start got err=%b pulses=%0d want err=1 pulses=0", er, startPulses - p0);
    end
    busAccess(1'b1, 32'h4, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h1) begin
      nFail++;
      $display("[TB] FAIL busy_status got %h want 1", rd);
    end
    convDone = 1'b1;
    mBusy = 1'b0;
    mDone = 1'b1;
    mRuns++;
    repeat (2) @(negedge clk);
    convDone = 1'b0;
    // A second rising edge while idle must not count as a run.
    repeat (2) @(negedge clk);
    convDone = 1'b1;
    repeat (2) @(negedge clk);
    convDone = 1'b0;
    busAccess(1'b1, 32'hC, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== mRuns) begin
      nFail++;
      $display("[TB] FAIL busy_runs got %0d want %0d", rd, mRuns);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd;
    logic er, l1;
    startRun();
    repeat (4) @(negedge clk);
    cmdValid = 1'b1;
    cmdRead  = 1'b0;
    cmdAddr  = 32'h4;
    cmdWdata = 32'h2;
    cmdWmask = 4'hF;
    convDone = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    mBusy = 1'b0;
    mDone = 1'b1;
    mRuns++;
    busAccess(1'b1, 32'h4, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h2) begin
      nFail++;
      $display("[TB] FAIL w1c_race got status=%h want 2", rd);
    end
    convDone = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    @(negedge clk);
    cmdValid = 1'b1;
    cmdRead  = 1'b1;
    cmdAddr  = 32'h10;
    cmdWmask = 4'h0;
    rspReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmdAddr = 32'hC;
    held = rspRdata;
    for (int i = 0; i < 5; i++) begin
      nCmp++;
      if (rspValid !== 1'b1 || cmdReady !== 1'b0 || rspRdata !== 32'h434F_4E56) begin
        nFail++;
        $display("[TB] FAIL stall_%0d got vld=%b rdy=%b rdata=%h want 1 0 434f4e56",
                 i, rspValid, cmdReady, rspRdata);
      end
      @(negedge clk);
    end
    nCmp++;
    if (rspRdata !== held) begin
      nFail++;
      $display("[TB] FAIL stall_stable got %h want %h", rspRdata, held);
    end
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    nCmp++;
    if (rspValid !== 1'b1 || rspRdata !== mRuns) begin
      nFail++;
      $display("[TB] FAIL b2b_next got vld=%b rdata=%h want 1 %h", rspValid, rspRdata, mRuns);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, wd, addr, exp;
    logic [3:0] mask;
    logic er, l1, isRd;
    logic [2:0] idx;
    for (int n = 0; n < 60; n++) begin
      idx  = 3'($urandom_range(0, 7));
      isRd = 1'($urandom);
      mask = 4'($urandom);
      wd   = $urandom;
      if (idx == 3'd0) wd[0] = 1'b0;
      addr = {27'($urandom), idx, 2'($urandom)};
      exp  = modelRead(idx);
      busAccess(isRd, addr, wd, mask, rd, er, l1);
      nCmp++;
      if (er !== (idx >= 3'd5)) begin
        nFail++;
        $display("[TB] FAIL rand_err idx=%0d got %b want %b", idx, er, idx >= 3'd5);
      end
      if (isRd && idx != 3'd2) begin
        nCmp++;
        if (rd !== exp) begin
          nFail++;
          $display("[TB] FAIL rand_read idx=%0d got %h want %h", idx, rd, exp);
        end
      end
      if (!isRd && mask[0]) begin
        if (idx == 3'd0) mIrqEn = wd[1];
        if (idx == 3'd1 && wd[1]) mDone = 1'b0;
      end
      @(negedge clk);
      nCmp++;
      if (irq !== (mDone & mIrqEn)) begin
        nFail++;
        $display("[TB] FAIL rand_irq got %b want %b", irq, mDone & mIrqEn);
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [31:0] rd;
    logic er, l1;
    startRun();
    repeat (10) @(negedge clk);
    cmdValid = 1'b1;
    cmdRead  = 1'b1;
    cmdAddr  = 32'h8;
    rspReady = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmdValid = 1'b0;
    rst = 1'b1;
    #1;
    nCmp++;
    if (rspValid !== 1'b0 || irq !== 1'b0 || convStart !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL midrst_out got vld=%b irq=%b start=%b want 0 0 0", rspValid, irq, convStart);
    end
    @(negedge clk);
    rst = 1'b0;
    rspReady = 1'b1;
    mBusy = 1'b0;
    mDone = 1'b0;
    mIrqEn = 1'b0;
    mRuns = 0;
    busAccess(1'b1, 32'h4, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL midrst_status got %h want 0", rd);
    end
    busAccess(1'b1, 32'h8, 32'h0, 4'h0, rd, er, l1);
    nCmp++;
    if (rd !== 32'h0) begin
      nFail++;
      $display("[TB] FAIL midrst_cycles got %0d want 0", rd);
    end
  endtask

  initial begin
    nCmp = 0;
    nFail = 0;
    startPulses = 0;
    mIrqEn = 1'b0;
    mDone = 1'b0;
    mBusy = 1'b0;
    mRuns = 0;
    cmdValid = 1'b0;
    cmdAddr = '0;
    cmdRead = 1'b0;
    cmdWdata = '0;
    cmdWmask = '0;
    rspReady = 1'b1;
    convDone = 1'b0;
    rst = 1'b1;
    test_reset();
    test_id();
    test_run();
    test_start_busy();
    test_w1c_race();
    test_back_to_back();
    test_random();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
